hazard_unit_mc: RTL and testbench

Parametrised hazard/forwarding unit for the 5-stage RV32 pipeline (F/D/E/M/W). It adds sequential stall control for multi-cycle execute ops (MUL/DIV) with a per-op latency. It adds a no-forwarding build mode, x0-safe load-use detection and a saturating stall-cycle performance counter. It sits beside the datapath and drives stage stall/flush enables and E-stage operand mux selects.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/mc_stall_fsm.sv | 54 +++++
 rtl/hazard_unit_mc.sv | 128 ++++++++++++
 tb/tb_hazard_unit_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the RV32 hazard/forwarding unit: E-stage operand
// mux selects and multi-cycle stall FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mc_stall_fsm.sv
// Holds the pipeline for McLatE cycles while a multi-cycle op sits in E,
// then spends one DONE cycle letting the op leave E before rearming.
module mc_stall_fsm
    import hazard_pkg::*;
#(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             McStartE,
    input  logic [LAT_W-1:0] McLatE,
    output logic             mcStall,
    output mc_state_e        state
);

    mc_state_e        state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcStall = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (McStartE && (McLatE != '0)) begin
                    mcStall = 1'b1;
                    cnt_d   = McLatE - LAT_W'(1);
                    state_d = (McLatE == LAT_W'(1)) ? MC_DONE : MC_BUSY;
                end
            end
            MC_BUSY: begin
                mcStall = 1'b1;
                cnt_d   = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) state_d = MC_DONE;
            end
            // McStartE still reflects the departing op here, so it is ignored.
            MC_DONE: state_d = MC_IDLE;
            default: state_d = MC_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage RV32 pipeline: load-use / RAW stalls,
// branch flushes, M/W->E forwarding and multi-cycle execute stalls.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              ResultSrcE_0,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic [LAT_W-1:0]  McLatE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy,
    output logic [CNT_W-1:0]  StallCnt
);

    logic       mcStall;
    logic       lwStall;
    logic [1:0] fwdA, fwdB;
    mc_state_e  unused_mc_state;  // exported by the FSM for debug probing only

    mc_stall_fsm #(.LAT_W(LAT_W)) u_mc (
        .clk      (clk),
        .resetn   (resetn),
        .McStartE (McStartE),
        .McLatE   (McLatE),
        .mcStall  (mcStall),
        .state    (unused_mc_state)
    );

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rdm,
                                           input logic              rwm,
                                           input logic [REG_AW-1:0] rdw,
                                           input logic              rww);
        if (rwm && (rdm == rs) && (rs != '0)) return FWD_MEM;
        if (rww && (rdw == rs) && (rs != '0)) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic [REG_AW-1:0] rs2);
        return (rd != '0) && ((rs1 == rd) || (rs2 == rd));
    endfunction

    if (FWD_EN) begin : g_fwd
        logic unused_fwd;
        assign unused_fwd = RegWriteE;
        assign lwStall = ResultSrcE_0 && src_hit(RdE, Rs1D, Rs2D);
        assign fwdA    = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        assign fwdB    = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end else begin : g_nofwd
        logic unused_nofwd;
        assign unused_nofwd = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE_0};
        // Regfile writes before it reads, so only E and M producers need a stall.
        assign lwStall = (RegWriteE && src_hit(RdE, Rs1D, Rs2D)) ||
                         (RegWriteM && src_hit(RdM, Rs1D, Rs2D));
        assign fwdA    = FWD_RF;
        assign fwdB    = FWD_RF;
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        McBusy    = 1'b0;
        if (resetn) begin
            ForwardAE = fwdA;
            ForwardBE = fwdB;
            McBusy    = mcStall;
            if (mcStall) begin
                // Freeze F/D/E and bubble M; branch and load-use wait for DONE.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else begin
                StallF = lwStall;
                StallD = lwStall;
                FlushD = PCSrcE;
                FlushE = lwStall | PCSrcE;
            end
        end
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (StallF && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign StallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench: one forwarding build and one stall-only build (4-bit counter)
// share stimulus; a counting reference model predicts both every cycle.
module tb_hazard_unit_mc;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic       rwe, ld, pc, mcs;
        logic [3:0] lat;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
    } in_t;

    typedef struct packed {
        logic        sf, sd, se, fd, fe, fm;
        logic [1:0]  fa, fb;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        exp_t e1;
        exp_t e0;
        int   id;
    } item_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic RegWriteE = 0, ResultSrcE_0 = 0, PCSrcE = 0, McStartE = 0, RegWriteM = 0, RegWriteW = 0;
    logic [3:0] McLatE = '0;

    logic sf1, sd1, se1, fd1, fe1, fm1, bz1;
    logic [1:0] fa1, fb1;
    logic [31:0] cnt1;
    logic sf0, sd0, se0, fd0, fe0, fm0, bz0;
    logic [1:0] fa0, fb0;
    logic [3:0] cnt0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .LAT_W(4), .FWD_EN(1'b1), .CNT_W(32)) u_fwd (
        .clk(clk), .resetn(resetn), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE_0(ResultSrcE_0), .PCSrcE(PCSrcE),
        .McStartE(McStartE), .McLatE(McLatE), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .StallF(sf1), .StallD(sd1), .StallE(se1),
        .FlushD(fd1), .FlushE(fe1), .FlushM(fm1), .ForwardAE(fa1), .ForwardBE(fb1),
        .McBusy(bz1), .StallCnt(cnt1));

    hazard_unit_mc #(.REG_AW(5), .LAT_W(4), .FWD_EN(1'b0), .CNT_W(4)) u_nof (
        .clk(clk), .resetn(resetn), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE_0(ResultSrcE_0), .PCSrcE(PCSrcE),
        .McStartE(McStartE), .McLatE(McLatE), .RdM(RdM), .RegWriteM(RegWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .StallF(sf0), .StallD(sd0), .StallE(se0),
        .FlushD(fd0), .FlushE(fe0), .FlushM(fm0), .ForwardAE(fa0), .ForwardBE(fb0),
        .McBusy(bz0), .StallCnt(cnt0));

    item_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference state: stall cycles left for the current op, pending DONE cycle,
    // and saturating stall counts for each build.
    int mc_left = 0;
    bit mc_done = 0;
    longint sc1 = 0, sc0 = 0;

    function automatic logic [1:0] fwd_ref(input in_t x, input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (x.rwm && x.rdm == rs) return 2'd2;
        if (x.rww && x.rdw == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit reads(input in_t x, input logic [4:0] rd);
        return rd != 0 && (x.rs1d == rd || x.rs2d == rd);
    endfunction

    function automatic exp_t predict(input in_t x, input bit fwd, input bit mc, input longint cnt);
        exp_t e;
        bit hz;
        e = '0;
        e.cnt = cnt[31:0];
        if (fwd) hz = x.ld && reads(x, x.rde);
        else     hz = (x.rwe && reads(x, x.rde)) || (x.rwm && reads(x, x.rdm));
        if (fwd) begin
            e.fa = fwd_ref(x, x.rs1e);
            e.fb = fwd_ref(x, x.rs2e);
        end
        e.busy = mc;
        if (mc) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
        end else begin
            e.sf = hz; e.sd = hz; e.fd = x.pc; e.fe = hz | x.pc;
        end
        return e;
    endfunction

    task automatic apply(input in_t x);
        Rs1D = x.rs1d; Rs2D = x.rs2d; Rs1E = x.rs1e; Rs2E = x.rs2e; RdE = x.rde;
        RegWriteE = x.rwe; ResultSrcE_0 = x.ld; PCSrcE = x.pc; McStartE = x.mcs;
        McLatE = x.lat; RdM = x.rdm; RegWriteM = x.rwm; RdW = x.rdw; RegWriteW = x.rww;
    endtask

    task automatic step(input in_t x);
        item_t it;
        bit mc;
        @(posedge clk); #1;
        resetn = 1'b1;
        apply(x);
        if (mc_done) begin
            mc = 0;
            mc_done = 0;
        end else begin
            if (mc_left == 0 && x.mcs && x.lat != 0) mc_left = int'(x.lat);
            mc = mc_left > 0;
            if (mc) begin
                mc_left--;
                if (mc_left == 0) mc_done = 1;
            end
        end
        it.e1 = predict(x, 1'b1, mc, sc1);
        it.e0 = predict(x, 1'b0, mc, sc0);
        it.id = cyc++;
        q.push_back(it);
        if (it.e1.sf && sc1 < 64'hFFFF_FFFF) sc1++;
        if (it.e0.sf && sc0 < 15) sc0++;
    endtask

    task automatic do_reset(input in_t x);
        item_t it;
        @(posedge clk); #1;
        resetn = 1'b0;
        apply(x);
        mc_left = 0; mc_done = 0; sc1 = 0; sc0 = 0;
        it.e1 = '0;
        it.e0 = '0;
        it.id = cyc++;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t a1, a0;
            it = q.pop_front();
            a1 = {sf1, sd1, se1, fd1, fe1, fm1, fa1, fb1, bz1, cnt1};
            a0 = {sf0, sd0, se0, fd0, fe0, fm0, fa0, fb0, bz0, 28'd0, cnt0};
            checks += 2;
            if (a1 !== it.e1) begin
                errors++;
                $display("FAIL fwd_build cyc%0d: got %h want %h", it.id, a1, it.e1);
            end
            if (a0 !== it.e0) begin
                errors++;
                $display("FAIL nofwd_build cyc%0d: got %h want %h", it.id, a0, it.e0);
            end
        end
    end

    initial begin
        in_t x;
        x = '0;
        do_reset(x);
        do_reset(x);
        // load-use, then x0 destination
        x = '0; x.ld = 1; x.rde = 5; x.rs1d = 5; step(x);
        x = '0; x.ld = 1; x.rde = 0; x.rs1d = 0; step(x);
        // forwarding priority M over W, W alone, x0 source
        x = '0; x.rwm = 1; x.rdm = 3; x.rww = 1; x.rdw = 3; x.rs1e = 3; x.rs2e = 3; step(x);
        x.rwm = 0; step(x);
        x.rs1e = 0; step(x);
        // RAW from M in the stall-only build
        x = '0; x.rwm = 1; x.rdm = 7; x.rs2d = 7; step(x);
        // multi-cycle, held start, then zero latency
        x = '0; x.mcs = 1; x.lat = 3;
        repeat (5) step(x);
        x.mcs = 0; step(x);
        x.mcs = 1; x.lat = 0; step(x); step(x);
        // branch during BUSY is masked, then unmasked in DONE and IDLE
        x = '0; x.mcs = 1; x.lat = 3; step(x);
        x.pc = 1; step(x); step(x); step(x);
        x.mcs = 0; step(x);
        // latency 1
        x = '0; x.mcs = 1; x.lat = 1; step(x); step(x);
        x.mcs = 0; step(x);
        // reset while BUSY with cnt=2, then confirm FSM is IDLE
        x = '0; x.mcs = 1; x.lat = 4; step(x); step(x);
        do_reset(x);
        x.mcs = 0; step(x);
        x.mcs = 1; x.lat = 2; step(x); step(x); step(x);
        x.mcs = 0; step(x);
        // saturate the 4-bit counter
        x = '0; x.ld = 1; x.rwe = 1; x.rde = 2; x.rs1d = 2;
        repeat (20) step(x);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            x.rs1d = 5'($urandom_range(0, 3)); x.rs2d = 5'($urandom_range(0, 3));
            x.rs1e = 5'($urandom_range(0, 3)); x.rs2e = 5'($urandom_range(0, 3));
            x.rde  = 5'($urandom_range(0, 3)); x.rdm  = 5'($urandom_range(0, 3));
            x.rdw  = 5'($urandom_range(0, 3));
            x.rwe = 1'($urandom); x.rwm = 1'($urandom); x.rww = 1'($urandom);
            x.ld  = ($urandom_range(0, 3) == 0);
            x.pc  = ($urandom_range(0, 7) == 0);
            x.mcs = ($urandom_range(0, 5) == 0);
            x.lat = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) do_reset(x);
            else step(x);
        end
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d items left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
